write_back_stage: RTL

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/write_back_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: result select into a 2-entry in-order buffer feeding the register file.
// Optional macro WB_LOAD_EXT_EN enables byte/half load extension on the memory path.
module write_back_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int RET_INC = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iMemData,
    input  logic [DATA_W-1:0] iExuData,
    input  logic              iMemToReg,
    input  logic              iRetCmd,
    input  logic [1:0]        iLoadSize,
    input  logic              iLoadSigned,
    input  logic [ADDR_W-1:0] iWrAddr,
    output logic              oWrEn,
    input  logic              iWrAck,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWriteData,
    output logic [1:0]        oOccupancy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_data [2];
    logic [ADDR_W-1:0] r_addr [2];

    logic              w_accept;
    logic              w_ack;
    logic              w_slot;
    logic [DATA_W-1:0] w_mem;
    logic [DATA_W-1:0] w_result;

    // Return-address increment wraps modulo 2^DATA_W; the carry is dropped.
    function automatic logic [DATA_W-1:0] f_ret_add(input logic [DATA_W-1:0] d);
        return d + DATA_W'(RET_INC);
    endfunction

`ifdef WB_LOAD_EXT_EN
    function automatic logic [DATA_W-1:0] f_load_ext(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              sgn
    );
        case (size)
            2'b00:   return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
            2'b01:   return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign w_mem = f_load_ext(iMemData, iLoadSize, iLoadSigned);
`else
    logic w_unused_load;
    assign w_unused_load = ^{iLoadSize, iLoadSigned};
    assign w_mem         = iMemData;
`endif

    assign w_result = iMemToReg ? w_mem :
                      iRetCmd   ? f_ret_add(iExuData) : iExuData;

    assign oReady   = (r_occ != S_FULL) || iWrAck;
    assign w_accept = iValid && oReady;
    assign w_ack    = iWrAck && (r_occ != S_EMPTY);
    // New entry lands behind whatever survives this cycle's ack.
    assign w_slot   = (r_occ == S_FULL) || ((r_occ == S_ONE) && !w_ack);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_occ <= S_EMPTY;
        end else begin
            case ({w_accept, w_ack})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage carries no reset; outputs are masked by occupancy instead.
    always_ff @(posedge iClk) begin
        if (w_ack) begin
            r_data[0] <= r_data[1];
            r_addr[0] <= r_addr[1];
        end
        if (w_accept) begin
            r_data[w_slot] <= w_result;
            r_addr[w_slot] <= iWrAddr;
        end
    end

    assign oWrEn      = (r_occ != S_EMPTY);
    assign oOccupancy = r_occ;
    assign oWrAddr    = oWrEn ? r_addr[0] : '0;
    assign oWriteData = oWrEn ? r_data[0] : '0;

endmodule
